// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers, one result bit per cycle.
// Build option: define MDU_DIV_EN to include the restoring divider; otherwise div/divu complete as no-ops.
`timescale 1ns/1ps

module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // mult: running upper half; div: partial remainder
  logic [WIDTH-1:0] wrk_q, wrk_d;   // mult: multiplier / lower half; div: dividend -> quotient
  logic [WIDTH-1:0] opd_q, opd_d;   // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d, dbz_q, dbz_d;
`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d, neg_hi_q, neg_hi_d;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
`endif

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   acc_nx, wrk_nx;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // One iteration of the datapath; the FSM decides whether to commit it.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opd_q} : '0);
    acc_nx  = mul_sum[WIDTH:1];
    wrk_nx  = {mul_sum[0], wrk_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    div_shift = {acc_q, wrk_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    div_ge    = ~div_diff[WIDTH];
    if (is_div_q) begin
      acc_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      wrk_nx = {wrk_q[WIDTH-2:0], div_ge};
    end
`endif
    prod   = {acc_nx, wrk_nx};
    prod_s = neg_lo_q ? -prod : prod;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    opd_d    = opd_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
`endif
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = acc_nx;
        wrk_d = wrk_nx;
        if (cnt_d == '0) begin
          state_d = S_DONE;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            lo_d = neg_lo_q ? -wrk_nx : wrk_nx;
            hi_d = neg_hi_q ? -acc_nx : acc_nx;
          end else
`endif
          {hi_d, lo_d} = prod_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          cnt_d    = CNT_W'(WIDTH);
          acc_d    = '0;
          neg_lo_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          if (op[1]) begin
`ifdef MDU_DIV_EN
            is_div_d = 1'b1;
            neg_hi_d = signed_op & a[WIDTH-1];
            wrk_d    = mag_a;
            opd_d    = mag_b;
            if (b == '0) begin
              state_d = S_DONE;
              hi_d    = a;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end else begin
              state_d = S_RUN;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
`ifdef MDU_DIV_EN
            is_div_d = 1'b0;
`endif
            wrk_d   = mag_b;
            opd_d   = mag_a;
            state_d = S_RUN;
          end
        end
      end
    endcase
    // Flush overrides everything, including a same-cycle start.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      opd_q    <= '0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      opd_q    <= opd_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a driver pushes expected results, a monitor checks each done pulse.
`timescale 1ns/1ps

module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, sp;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.hi = model_hi; e.lo = model_lo; e.dbz = 1'b0; e.lat = W + 1; e.start_cyc = 0;
    case (o)
      2'b00: begin sp = sx * sy; {e.hi, e.lo} = sp; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; {e.hi, e.lo} = up; end
      default: begin
`ifdef MDU_DIV_EN
        if (y == '0) begin
          e.hi = x; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
        end else if (o == 2'b10) begin
          e.lo = 32'(sx / sy); e.hi = 32'(sx % sy);
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
`else
        e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_by_zero", div_by_zero, mon_e.dbz);
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
      end
    end
    if (!rst && div_by_zero && !done) check("dbz_without_done", 64'd1, 64'd0);
  end

  // Called one time unit after a rising edge; drives start for exactly one cycle.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    exp_t e;
    int   busy_cnt;
    bit   got;
    e = ref_model(o, x, y);
    e.start_cyc = cyc;
    sb_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    launch(o, x, y);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) busy_cnt++;
      if (poke && i == 4) begin start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom; end
      if (poke && i == 6) start = 1'b0;
      @(posedge clk); #1;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
    check("busy_cycles", 64'(busy_cnt), (e.lat == W + 1) ? 64'(W) : 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;
    idle(1);

    // Directed corner cases, issued back-to-back in each DONE cycle.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(3);
    run_op(2'b00, 32'd12345, 32'hFFFF_E57B, 1'b0);

    // Flush ten cycles into RUN: no done, results held.
    launch(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    idle(9);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    // Flush and start together: start must be dropped.
    flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    idle(1);
    flush = 1'b0; start = 1'b0;
    check("flush_start_busy", busy, 0);
    check("flush_start_done", done, 0);
    idle(40);
    check("flush_hi_hold", hi, model_hi);
    check("flush_lo_hold", lo, model_lo);

    // Randomized operations with occasional idle gaps and starts-while-busy.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = '0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 300));
      run_op(ro, rx, ry, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    // Reset in the middle of RUN clears all outputs at once.
    idle(2);
    launch(2'b01, 32'h0F0F_0F0F, 32'h7777_7777);
    idle(10);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dbz", div_by_zero, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    model_hi = '0;
    model_lo = '0;
    idle(1);
    rst = 1'b0;
    idle(1);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b01, 32'd3, 32'd5, 1'b0);

    idle(5);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
